// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register: MSB-first capture while load is high,
// with a one-cycle frame_valid strobe on every completed WIDTH-bit word.
`timescale 1ns/1ps

module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din,
  input  logic                       load,
  output logic [WIDTH-1:0]           dout,
  output logic                       frame_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Dropping load abandons any partial frame but keeps dout on display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= '0;
      bit_count   <= '0;
      frame_valid <= 1'b0;
    end else if (load) begin
      dout <= {dout[WIDTH-2:0], din};
      if (bit_count == LAST_BIT) begin
        bit_count   <= '0;
        frame_valid <= 1'b1;
      end else begin
        bit_count   <= bit_count + CW'(1);
        frame_valid <= 1'b0;
      end
    end else begin
      bit_count   <= '0;
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Bench for sipo_shift_reg: 8-bit and 4-bit builds share stimulus and are checked
// against a bit-history model, a constant vector table and hand-written sequences.
`timescale 1ns/1ps

module tb_sipo_shift_reg;

  logic clk = 1'b0;
  logic rst_n;
  logic din;
  logic load;

  logic [7:0] dout8;
  logic       fv8;
  logic [3:0] bc8;
  logic [3:0] dout4;
  logic       fv4;
  logic [2:0] bc4;

  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  sipo_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
    .dout(dout8), .frame_valid(fv8), .bit_count(bc8)
  );

  sipo_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load),
    .dout(dout4), .frame_valid(fv4), .bit_count(bc4)
  );

  // Reference: every bit shifted since reset, plus the length of the current load run.
  bit hist[$];
  int run;
  bit lastShift;

  function automatic void modelReset();
    hist.delete();
    run = 0;
    lastShift = 1'b0;
  endfunction

  function automatic void modelEdge(bit d, bit l);
    if (l) begin
      hist.push_back(d);
      run++;
      lastShift = 1'b1;
    end else begin
      run = 0;
      lastShift = 1'b0;
    end
  endfunction

  function automatic logic [31:0] expDout(int w);
    logic [31:0] r = '0;
    for (int i = 0; i < w; i++)
      if (hist.size() > i) r[i] = hist[hist.size() - 1 - i];
    return r;
  endfunction

  function automatic logic [31:0] expBc(int w);
    return 32'(run % w);
  endfunction

  function automatic logic [31:0] expFv(int w);
    return {31'b0, lastShift && run > 0 && (run % w) == 0};
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag);
    checkVal({tag, " dout8"}, 32'(dout8), expDout(8));
    checkVal({tag, " fv8"},   32'(fv8),   expFv(8));
    checkVal({tag, " bc8"},   32'(bc8),   expBc(8));
    checkVal({tag, " dout4"}, 32'(dout4), expDout(4));
    checkVal({tag, " fv4"},   32'(fv4),   expFv(4));
    checkVal({tag, " bc4"},   32'(bc4),   expBc(4));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic applyStimulus(bit d, bit l, string tag);
    din  = d;
    load = l;
    @(posedge clk);
    modelEdge(d, l);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic doReset();
    #0.3 rst_n = 1'b0;
    #0.2;
    modelReset();
    checkOutput("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         d;
    bit         l;
    logic [7:0] dout;
    bit         fv;
    logic [3:0] bc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pulses;
    logic [15:0] word;

    rst_n = 1'b1;
    din   = 1'b0;
    load  = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();

    // Constant vector table: single frame, then hold after three ones.
    tbl.push_back('{1, 1, 1, 8'h01, 0, 4'd1});
    tbl.push_back('{0, 0, 1, 8'h02, 0, 4'd2});
    tbl.push_back('{0, 1, 1, 8'h05, 0, 4'd3});
    tbl.push_back('{0, 1, 1, 8'h0B, 0, 4'd4});
    tbl.push_back('{0, 0, 1, 8'h16, 0, 4'd5});
    tbl.push_back('{0, 0, 1, 8'h2C, 0, 4'd6});
    tbl.push_back('{0, 1, 1, 8'h59, 0, 4'd7});
    tbl.push_back('{0, 0, 1, 8'hB2, 1, 4'd0});
    tbl.push_back('{0, 1, 0, 8'hB2, 0, 4'd0});
    tbl.push_back('{1, 1, 1, 8'h01, 0, 4'd1});
    tbl.push_back('{0, 1, 1, 8'h03, 0, 4'd2});
    tbl.push_back('{0, 1, 1, 8'h07, 0, 4'd3});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{0, bit'(i % 2), 0, 8'h07, 0, 4'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) doReset();
      applyStimulus(tbl[i].d, tbl[i].l, "table");
      checkVal($sformatf("tbl[%0d] dout", i), 32'(dout8), 32'(tbl[i].dout));
      checkVal($sformatf("tbl[%0d] fv", i),   32'(fv8),   32'(tbl[i].fv));
      checkVal($sformatf("tbl[%0d] bc", i),   32'(bc8),   32'(tbl[i].bc));
    end

    // Back-to-back frames 8'hA5 then 8'h3C with no gap.
    doReset();
    word = 16'hA53C;
    for (int i = 15; i >= 0; i--) begin
      applyStimulus(word[i], 1'b1, "b2b");
      if (i == 8) begin
        checkVal("b2b frame1 dout", 32'(dout8), 32'h A5);
        checkVal("b2b frame1 fv",   32'(fv8),   32'h1);
      end
      if (i == 0) begin
        checkVal("b2b frame2 dout", 32'(dout8), 32'h3C);
        checkVal("b2b frame2 fv",   32'(fv8),   32'h1);
      end
    end

    // WIDTH=4 build: 1,0,0,1 gives 4'h9 with the strobe on the 4th edge.
    doReset();
    applyStimulus(1'b1, 1'b1, "w4");
    applyStimulus(1'b0, 1'b1, "w4");
    applyStimulus(1'b0, 1'b1, "w4");
    checkVal("w4 no early strobe", 32'(fv4), 32'h0);
    applyStimulus(1'b1, 1'b1, "w4");
    checkVal("w4 dout", 32'(dout4), 32'h9);
    checkVal("w4 strobe", 32'(fv4), 32'h1);

    // Async reset mid-shift, held across edges with load high and din toggling.
    doReset();
    applyStimulus(1'b1, 1'b1, "pre_rst");
    applyStimulus(1'b0, 1'b1, "pre_rst");
    applyStimulus(1'b1, 1'b1, "pre_rst");
    #0.3 rst_n = 1'b0;
    #0.2;
    modelReset();
    checkVal("midrst dout", 32'(dout8), 32'h0);
    checkVal("midrst bc",   32'(bc8),   32'h0);
    checkVal("midrst fv",   32'(fv8),   32'h0);
    for (int i = 0; i < 3; i++) begin
      din  = ~din;
      load = 1'b1;
      @(negedge clk);
      checkOutput("rst_held");
    end
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, "post_rst");

    // Slow pattern: din toggles every 5 ns against a 2 ns clock.
    doReset();
    load   = 1'b1;
    pulses = 0;
    fork
      begin
        #0.5;
        repeat (17) begin
          din = ~din;
          #5;
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk);
          modelEdge(din, load);
          @(negedge clk);
          checkOutput("slow");
          if (fv8) pulses++;
        end
      end
    join
    checkVal("slow strobe count", 32'(pulses), 32'd5);

    // Randomized traffic with occasional load gaps and resets.
    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      applyStimulus(bit'($urandom % 2), ($urandom % 6) != 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
